// File: rtl/divider_pkg.sv
// Shared constants for the multi-channel clock divider.
package divider_pkg;
  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;
  localparam int   MIN_DIVIDE  = 2;
endpackage

// File: rtl/multi_divider_if.sv
// Config request channel: per-channel ratio/mode writes with valid/ready.
interface multi_divider_if #(
  parameter int CHANNELS    = 4,
  parameter int DIVIDE_BITS = 16
) ();
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CHAN_W-1:0]      cfg_chan;
  logic [DIVIDE_BITS-1:0] cfg_divide;
  logic                   cfg_mode;

  modport master (output cfg_valid, cfg_chan, cfg_divide, cfg_mode, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_divide, cfg_mode, output cfg_ready);
endinterface

// File: rtl/divider_channel.sv
// One divider channel: counter, active/shadow ratio+mode, registered out/tick.
module divider_channel
  import divider_pkg::*;
#(
  parameter int DIVIDE_BITS    = 16,
  parameter int DEFAULT_DIVIDE = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   sync,
  input  logic                   load,
  input  logic [DIVIDE_BITS-1:0] load_divide,
  input  logic                   load_mode,
  output logic                   pending,
  output logic                   out,
  output logic                   tick
);
  logic [DIVIDE_BITS-1:0] count, div, sh_div, next_count, clamped;
  logic [DIVIDE_BITS:0]   half;
  logic                   mode, sh_mode, wrap, boundary, eff_mode;

  always_comb begin
    wrap       = (count == div - 1'b1);
    boundary   = !enable || sync || wrap;
    next_count = count + 1'b1;
    half       = ({1'b0, div} + 1'b1) >> 1;
    eff_mode   = pending ? sh_mode : mode;
    clamped    = (load_divide < DIVIDE_BITS'(MIN_DIVIDE)) ? DIVIDE_BITS'(MIN_DIVIDE) : load_divide;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      div     <= DIVIDE_BITS'(DEFAULT_DIVIDE);
      mode    <= MODE_PULSE;
      sh_div  <= DIVIDE_BITS'(DEFAULT_DIVIDE);
      sh_mode <= MODE_PULSE;
      pending <= 1'b0;
      out     <= 1'b0;
      tick    <= 1'b0;
    end else begin
      // load only fires while not pending, so it never races the shadow copy
      if (load) begin
        sh_div  <= clamped;
        sh_mode <= load_mode;
        pending <= 1'b1;
      end else if (boundary && pending) begin
        div     <= sh_div;
        mode    <= sh_mode;
        pending <= 1'b0;
      end

      if (!enable) begin
        count <= '0;
        out   <= 1'b0;
        tick  <= 1'b0;
      end else if (sync) begin
        count <= '0;
        tick  <= 1'b0;
        out   <= (eff_mode == MODE_SQUARE);
      end else if (wrap) begin
        // count 0 is always inside the high half, so both modes go high
        count <= '0;
        tick  <= 1'b1;
        out   <= 1'b1;
      end else begin
        count <= next_count;
        tick  <= 1'b0;
        out   <= (mode == MODE_SQUARE) && ({1'b0, next_count} < half);
      end
    end
  end
endmodule

// File: rtl/multi_divider.sv
// Multi-channel divider: config decode, ready mux and sync fan-out over channels.
module multi_divider
  import divider_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int DIVIDE_BITS    = 16,
  parameter int DEFAULT_DIVIDE = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  input  logic                sync,
  multi_divider_if.slave      cfg,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] tick
);
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] pending, load;
  logic                ready;

  // out-of-range channels leave ready high and load nothing
  always_comb begin
    ready = 1'b1;
    load  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_chan == CHAN_W'(i)) begin
        ready   = !pending[i];
        load[i] = cfg.cfg_valid && !pending[i];
      end
    end
  end

  assign cfg.cfg_ready = ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    divider_channel #(
      .DIVIDE_BITS   (DIVIDE_BITS),
      .DEFAULT_DIVIDE(DEFAULT_DIVIDE)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable[i]),
      .sync       (sync),
      .load       (load[i]),
      .load_divide(cfg.cfg_divide),
      .load_mode  (cfg.cfg_mode),
      .pending    (pending[i]),
      .out        (out[i]),
      .tick       (tick[i])
    );
  end
endmodule

// File: tb/tb_multi_divider.sv
// Randomized/directed bench for multi_divider against a period/phase reference model.
module tb_multi_divider;
  localparam int CH = 5;
  localparam int DB = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          sync;
  logic [CH-1:0] d_out, d_tick;

  multi_divider_if #(.CHANNELS(CH), .DIVIDE_BITS(DB)) cif ();

  multi_divider #(.CHANNELS(CH), .DIVIDE_BITS(DB), .DEFAULT_DIVIDE(100)) dut (
    .clk(clk), .rst(rst), .enable(en), .sync(sync), .cfg(cif),
    .out(d_out), .tick(d_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0;

  // reference: period n, phase pos within period, shadow + pending per channel
  int            mn[CH], msn[CH], mpos[CH];
  bit            mmd[CH], msmd[CH], mpend[CH];
  logic [CH-1:0] e_out, e_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      mn[i] = 100; msn[i] = 100; mpos[i] = 0;
      mmd[i] = 0; msmd[i] = 0; mpend[i] = 0;
    end
    e_out = '0; e_tick = '0;
  endtask

  task automatic model_step();
    bit acc, wrap, bnd;
    for (int i = 0; i < CH; i++) begin
      acc = cif.cfg_valid && (int'(cif.cfg_chan) == i) && !mpend[i];
      if (!en[i]) begin
        if (mpend[i]) begin mn[i] = msn[i]; mmd[i] = msmd[i]; mpend[i] = 0; end
        mpos[i] = 0; e_out[i] = 0; e_tick[i] = 0;
      end else begin
        wrap = (mpos[i] == mn[i] - 1);
        bnd  = sync || wrap;
        if (bnd && mpend[i]) begin mn[i] = msn[i]; mmd[i] = msmd[i]; mpend[i] = 0; end
        e_tick[i] = !sync && wrap;
        mpos[i]   = bnd ? 0 : mpos[i] + 1;
        e_out[i]  = mmd[i] ? (mpos[i] < (mn[i] + 1) / 2) : e_tick[i];
      end
      if (acc) begin
        msn[i] = (cif.cfg_divide < 2) ? 2 : int'(cif.cfg_divide);
        msmd[i] = cif.cfg_mode; mpend[i] = 1;
      end
    end
  endtask

  task automatic cycle();
    bit exp_rdy;
    #1;
    exp_rdy = (int'(cif.cfg_chan) >= CH) ? 1'b1 : !mpend[int'(cif.cfg_chan)];
    chk("cfg_ready", cif.cfg_ready, exp_rdy);
    model_step();
    @(posedge clk); #1;
    chk("out", d_out, e_out);
    chk("tick", d_tick, e_tick);
  endtask

  task automatic send(input int ch, input int n, input bit md);
    cif.cfg_valid = 1; cif.cfg_chan = 3'(ch); cif.cfg_divide = DB'(n); cif.cfg_mode = md;
    cycle();
    cif.cfg_valid = 0;
  endtask

  task automatic wait_pos(input int ch, input int p);
    int k = 0;
    while (mpos[ch] != p && k < 300) begin cycle(); k++; end
    if (k >= 300) chk("wait_pos_timeout", k, 0);
  endtask

  task automatic wait_clear(input int ch);
    int k = 0;
    while (mpend[ch] && k < 300) begin cycle(); k++; end
    if (k >= 300) chk("wait_clear_timeout", k, 0);
  endtask

  task automatic measure_tick(input int ch, input int exp, input string tag);
    int k = 0;
    do begin cycle(); k++; end while (!d_tick[ch] && k < 300);
    chk(tag, k, exp);
  endtask

  initial begin
    int k;
    rst = 0; en = '0; sync = 0;
    cif.cfg_valid = 0; cif.cfg_chan = '0; cif.cfg_divide = '0; cif.cfg_mode = 0;
    model_reset();
    #100;
    chk("reset_out", d_out, 0);
    chk("reset_tick", d_tick, 0);
    @(posedge clk); #1; rst = 1;

    // default ratio 100 on ch0
    en[0] = 1;
    measure_tick(0, 100, "first_tick_n100");
    measure_tick(0, 100, "second_tick_n100");

    // odd square on ch1 configured while disabled
    send(1, 3, 1);
    cycle();
    en[1] = 1;
    measure_tick(1, 3, "sq3_first");
    measure_tick(1, 3, "sq3_period");
    repeat (7) cycle();

    // deferred update on ch0, second write blocked while pending
    send(0, 10, 0);
    wait_clear(0);
    wait_pos(0, 3);
    send(0, 4, 0);
    cif.cfg_valid = 1; cif.cfg_chan = 3'd0; cif.cfg_divide = 16'd7; cif.cfg_mode = 0;
    measure_tick(0, 6, "defer_old_period");
    cycle();
    cif.cfg_valid = 0;
    measure_tick(0, 3, "defer_period4_rest");
    measure_tick(0, 7, "defer_second_write");

    // write accepted on the wrap edge waits one more period
    wait_clear(0);
    send(0, 10, 0);
    wait_clear(0);
    wait_pos(0, 9);
    send(0, 5, 0);
    measure_tick(0, 10, "wrapwrite_old");
    measure_tick(0, 5, "wrapwrite_new");

    // sync alignment of ch0 N=6 and ch1 N=9
    send(0, 6, 0);
    send(1, 9, 0);
    repeat ($urandom_range(20, 3)) cycle();
    sync = 1; cycle(); sync = 0;
    k = 0;
    do begin cycle(); k++; end while (d_tick[1:0] != 2'b11 && k < 100);
    chk("sync_coincide", k, 18);

    // clamp of N=0 and out-of-range channel
    send(2, 0, 0);
    cycle();
    en[2] = 1;
    measure_tick(2, 2, "clamp_first");
    measure_tick(2, 2, "clamp_period");
    send(5, 3, 1);
    send(7, 0, 1);
    repeat (10) cycle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(15, 0) == 0) en = CH'($urandom);
      sync = ($urandom_range(40, 0) == 0);
      cif.cfg_valid  = ($urandom_range(3, 0) == 0);
      cif.cfg_chan   = 3'($urandom_range(7, 0));
      cif.cfg_divide = DB'($urandom_range(12, 0));
      cif.cfg_mode   = 1'($urandom);
      cycle();
    end
    sync = 0; cif.cfg_valid = 0;

    // async reset mid-period discards a pending write
    en = '1;
    repeat (4) cycle();
    wait_clear(0);
    send(0, 9, 1);
    #3; rst = 0; #1;
    chk("async_rst_out", d_out, 0);
    chk("async_rst_tick", d_tick, 0);
    model_reset();
    en = '0;
    @(posedge clk); #1; rst = 1;
    en[0] = 1;
    measure_tick(0, 100, "post_rst_n100");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/multi_divider.md
Name: multi_divider

Overview:
Parametrised multi-channel clock-enable/divider generator, successor to the single-channel divider. Each channel has its own runtime divide ratio, its own output mode (single-cycle pulse or ~50% square) and its own enable. New ratios and modes are loaded through a valid/ready config port and applied glitch-free at the next period boundary. A global sync input phase-aligns all channels. It drives slow strobes and derived clock-enables for peripheral logic.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16).
DIVIDE_BITS, 16, width of divide ratio and per-channel counter.
DEFAULT_DIVIDE, 100, ratio loaded into every channel at reset (must be >= 2 and < 2**DIVIDE_BITS).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-low reset (asserted when 0).
enable  in  CHANNELS  per-channel run enable.
sync  in  1  one-cycle request restarting all enabled channels at count 0.
cfg_valid  in  1  config request valid.
cfg_ready  out  1  config request accepted this cycle when valid&ready.
cfg_chan  in  max(1,$clog2(CHANNELS))  target channel.
cfg_divide  in  DIVIDE_BITS  new divide ratio N.
cfg_mode  in  1  0 = pulse, 1 = square.
out  out  CHANNELS  divided output, registered.
tick  out  CHANNELS  one-cycle strobe, registered, once per period.

Behaviour:
- Reset (rst=0, async): count=0, out=0, tick=0, div=DEFAULT_DIVIDE, mode=pulse, pending flags=0. Reset mid-operation discards pending config immediately.
- Ratio clamp: accepted N of 0 or 1 is stored as 2.
- Channel disabled (enable[i]=0): count held at 0, out[i]=0, tick[i]=0, sync ignored. A pending config applies on the next edge.
- Channel enabled: on each edge, count <= (count==div-1) ? 0 : count+1. This is a wrap when count==div-1.
- tick[i] <= 1 on the wrap edge, else 0. The first tick is visible after the Nth enabled edge; with N=100, tick is high for exactly one cycle every 100 cycles.
- Pulse mode: out[i] equals tick[i].
- Square mode: out[i] <= (next_count < H), where H = ceil(N/2). N=3 gives a 2-high/1-low pattern.
- sync=1: every enabled channel loads count=0 this edge, with tick=0 and out reflecting count 0. Sync has priority over wrap, and it also applies any pending config.
- Config handshake:
  - cfg_ready = !pending[cfg_chan], combinational.
  - On valid&ready, N and mode are written to that channel's shadow and pending is set.
  - Shadow is copied to active on the channel's next wrap, sync, or disabled edge, and pending then clears.
  - A write accepted in the same cycle as that channel's wrap does not take effect at that wrap; it waits for the following boundary.
- cfg_chan >= CHANNELS: cfg_ready=1, request accepted and dropped.
- Channels are fully independent; simultaneous wraps on all channels are legal.
- No combinational path from any input to out or tick.

Decomposition:
- Shared package divider_pkg: MODE_PULSE=1'b0 and MODE_SQUARE=1'b1 constants, MIN_DIVIDE=2.
- One natural sub-module, divider_channel: a single counter with active and shadow registers, pending flag, out/tick registers and a load strobe input. multi_divider instantiates CHANNELS copies and handles cfg decode, the ready mux and sync fan-out.

Test Plan:
- Reset defaults: hold rst=0 for 100ns, release, enable[0]=1 with N=100 → tick[0] high exactly one cycle at the 100th enabled edge, then every 100 cycles; out[0] identical.
- Square odd ratio: cfg ch1 N=3 mode=1 while disabled, then enable → out[1] pattern 1,1,0 repeating, tick[1] every 3 cycles.
- Deferred update: ch0 running N=10, write N=4 at count=3 → next wrap at 10 cycles, then period 4. A second write while pending → cfg_ready=0 until the boundary.
- Write on wrap cycle: accept N=5 on the same cycle as ch0's wrap (N=10) → one more 10-cycle period, then 5.
- Sync alignment: ch0 N=6, ch1 N=9 at arbitrary phases, pulse sync → both counts 0; ticks coincide 18 cycles later.
- Edge cases: cfg N=0 → behaves as N=2. cfg_chan=CHANNELS → accepted, no channel changes. rst asserted mid-period → all outputs 0 asynchronously, div back to 100.
